// File: rtl/dest_reg_scoreboard.sv
// rtl/dest_reg_scoreboard.sv - pending register-write scoreboard with RAW/WAW stall
//
// Purpose:
//   Tracks how many in-flight instructions will write each architectural
//   register. Issue-stage instructions whose sources are still pending, or
//   whose destination counter is saturated, are held by asserting stall.
//   Register 0 is never tracked.
//
// Ports:
//   Clk            in   pipeline clock, state updates on rising edge
//   Reset          in   asynchronous active-high reset
//   issue_valid    in   instruction in ID attempting to advance to EX
//   issue_regwrite in   RegWrite of the issuing instruction
//   issue_dest     in   destination register from the RegDst mux
//   rs, rt         in   source registers of the ID instruction
//   rs_used        in   instruction reads rs
//   rt_used        in   instruction reads rt
//   wb_valid       in   MEM/WB writes the register file this cycle
//   wb_dest        in   register being written back
//   kill_valid     in   a squashed in-flight writer will never write back
//   kill_dest      in   destination of the squashed writer
//   stall          out  hold PC and IF/ID, bubble into ID/EX
//   busy_mask      out  bit i set while register i has pending writes
//   err            out  sticky counter overflow/underflow flag
//
// Build option:
//   DEST_REG_SCOREBOARD_WB_BYPASS_EN - when defined, a RAW hazard on a
//   register whose last pending write is retiring this cycle is not stalled,
//   relying on the write-first register file read.

module dest_reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                issue_valid,
  input  logic                issue_regwrite,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic [ADDR_W-1:0]   rs,
  input  logic [ADDR_W-1:0]   rt,
  input  logic                rs_used,
  input  logic                rt_used,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dest,
  input  logic                kill_valid,
  input  logic [ADDR_W-1:0]   kill_dest,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                err
);

  localparam int              CNT_MAX_I = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] count      [NUM_REGS];
  logic [CNT_W-1:0] count_next [NUM_REGS];

  logic raw_rs;
  logic raw_rt;
  logic waw;
  logic accept;
  logic dec_wb;
  logic dec_kill;
  logic err_set;
  int   sum;

  always_comb begin : hazard
    raw_rs = rs_used && (rs != '0) && (count[rs] != '0);
    raw_rt = rt_used && (rt != '0) && (count[rt] != '0);
`ifdef DEST_REG_SCOREBOARD_WB_BYPASS_EN
    // The last outstanding write is landing now; the register file forwards it.
    if (wb_valid && (wb_dest == rs) && (count[rs] == CNT_W'(1))) raw_rs = 1'b0;
    if (wb_valid && (wb_dest == rt) && (count[rt] == CNT_W'(1))) raw_rt = 1'b0;
`endif
    waw   = issue_regwrite && (issue_dest != '0) && (count[issue_dest] == CNT_MAX);
    stall = issue_valid && (raw_rs || raw_rt || waw);
  end

  assign accept   = issue_valid && issue_regwrite && !stall && (issue_dest != '0);
  assign dec_wb   = wb_valid && (wb_dest != '0);
  assign dec_kill = kill_valid && (kill_dest != '0);

  // Net change per register is inc - wb - kill; evaluate it wide so that a
  // simultaneous issue and retire on the same register cancels cleanly and
  // only a genuinely negative or oversized result flags err.
  always_comb begin : next_state
    err_set       = 1'b0;
    sum           = 0;
    count_next[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      sum = int'(count[i]);
      if (accept   && (issue_dest == ADDR_W'(i))) sum = sum + 1;
      if (dec_wb   && (wb_dest    == ADDR_W'(i))) sum = sum - 1;
      if (dec_kill && (kill_dest  == ADDR_W'(i))) sum = sum - 1;
      if (sum < 0) begin
        count_next[i] = '0;
        err_set       = 1'b1;
      end else if (sum > CNT_MAX_I) begin
        count_next[i] = CNT_MAX;
        err_set       = 1'b1;
      end else begin
        count_next[i] = CNT_W'(sum);
      end
    end
  end

  always_comb begin : busy
    busy_mask[0] = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_mask[i] = (count[i] != '0);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) count[i] <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) count[i] <= count_next[i];
      err <= err | err_set;
    end
  end

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// tb/tb_dest_reg_scoreboard.sv - scoreboard bench for dest_reg_scoreboard

module tb_dest_reg_scoreboard;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        issue_valid, issue_regwrite, rs_used, rt_used, wb_valid, kill_valid;
  logic [4:0]  issue_dest, rs, rt, wb_dest, kill_dest;
  logic        stall, err;
  logic [31:0] busy_mask;

  dest_reg_scoreboard dut (
    .Clk(Clk), .Reset(Reset),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite), .issue_dest(issue_dest),
    .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .kill_valid(kill_valid), .kill_dest(kill_dest),
    .stall(stall), .busy_mask(busy_mask), .err(err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        stall;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mcnt[32];
  logic merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bypass(input logic [4:0] src);
`ifdef DEST_REG_SCOREBOARD_WB_BYPASS_EN
    return wb_valid && (wb_dest == src) && (mcnt[src] == 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_stall();
    logic s = 1'b0;
    if (issue_valid) begin
      if (rs_used && rs != 0 && mcnt[rs] > 0 && !bypass(rs)) s = 1'b1;
      if (rt_used && rt != 0 && mcnt[rt] > 0 && !bypass(rt)) s = 1'b1;
      if (issue_regwrite && issue_dest != 0 && mcnt[issue_dest] == 3) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (mcnt[r] > 0);
    return b;
  endfunction

  // Apply the inputs that were present at the clock edge just passed.
  task automatic model_step();
    logic acc;
    int   nv;
    acc = issue_valid && issue_regwrite && !model_stall() && issue_dest != 0;
    for (int r = 1; r < 32; r++) begin
      nv = mcnt[r];
      if (acc && issue_dest == r) nv++;
      if (wb_valid && wb_dest == r) nv--;
      if (kill_valid && kill_dest == r) nv--;
      if (nv < 0) begin nv = 0; merr = 1'b1; end
      if (nv > 3) begin nv = 3; merr = 1'b1; end
      mcnt[r] = nv;
    end
  endtask

  task automatic step(input logic iv, input logic rw, input logic [4:0] d,
                      input logic [4:0] a, input logic [4:0] b, input logic au, input logic bu,
                      input logic wv, input logic [4:0] wd, input logic kv, input logic [4:0] kd);
    exp_t e;
    @(posedge Clk);
    #1;
    model_step();
    issue_valid = iv; issue_regwrite = rw; issue_dest = d;
    rs = a; rt = b; rs_used = au; rt_used = bu;
    wb_valid = wv; wb_dest = wd; kill_valid = kv; kill_dest = kd;
    e.stall = model_stall();
    e.busy  = model_busy();
    e.err   = merr;
    q.push_back(e);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic zero_inputs();
    issue_valid = 0; issue_regwrite = 0; issue_dest = 0; rs = 0; rt = 0;
    rs_used = 0; rt_used = 0; wb_valid = 0; wb_dest = 0; kill_valid = 0; kill_dest = 0;
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && q.size() > 0) begin
      e = q.pop_front();
      chk("sb_stall", {31'd0, stall}, {31'd0, e.stall});
      chk("sb_busy", busy_mask, e.busy);
      chk("sb_err", {31'd0, err}, {31'd0, e.err});
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    merr = 1'b0;
    zero_inputs();
    Reset = 1'b1;
    #12;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_busy", busy_mask, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    idle();
    idle();

    // RAW on r8
    step(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 8, 0, 1, 0, 0, 0, 0, 0);
    chk("raw_stall", {31'd0, stall}, 32'd1);
    step(1, 0, 0, 8, 0, 1, 0, 1, 8, 0, 0);
`ifdef DEST_REG_SCOREBOARD_WB_BYPASS_EN
    chk("raw_wb_cycle", {31'd0, stall}, 32'd0);
`else
    chk("raw_wb_cycle", {31'd0, stall}, 32'd1);
`endif
    step(1, 0, 0, 8, 0, 1, 0, 0, 0, 0, 0);
    chk("raw_released", {31'd0, stall}, 32'd0);
    chk("busy8_clear", {31'd0, busy_mask[8]}, 32'd0);

    // WAW saturation on r5
    repeat (3) step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_stall", {31'd0, stall}, 32'd1);
    idle();
    chk("waw_no_err", {31'd0, err}, 32'd0);
    chk("waw_busy5", {31'd0, busy_mask[5]}, 32'd1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);

    // Simultaneous issue and writeback on r12
    step(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 12, 0, 0, 0, 0, 1, 12, 0, 0);
    idle();
    chk("same_cycle_busy12", {31'd0, busy_mask[12]}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0);

    // Underflow on r20, sticky err
    step(0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 0);
    idle();
    chk("underflow_err", {31'd0, err}, 32'd1);
    chk("underflow_busy20", {31'd0, busy_mask[20]}, 32'd0);
    idle();

    // Register 0 ignored
    step(1, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0);
    chk("r0_no_stall", {31'd0, stall}, 32'd0);
    idle();
    chk("r0_not_busy", busy_mask, 32'd0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 1, 5'($urandom_range(0, 7)));
    end

    // Asynchronous reset mid-cycle
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 3, 4, 1, 1, 0, 0, 0, 0);
    @(negedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("async_busy", busy_mask, 32'd0);
    chk("async_stall", {31'd0, stall}, 32'd0);
    chk("async_err", {31'd0, err}, 32'd0);
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
    merr = 1'b0;
    zero_inputs();
    @(negedge Clk);
    Reset = 1'b0;
    idle();
    idle();
    @(negedge Clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dest_reg_scoreboard.md
Name: dest_reg_scoreboard

Overview:
- Tracks pending register writes in the 5-stage MIPS pipeline.
- Consumes the destination register number chosen by the ID-stage RegDst 5-bit 2:1 mux (rt vs rd), together with the RegWrite control bit.
- Holds a per-register in-flight count, cleared by writeback or cancellation.
- Raises a RAW/WAW stall to the IF/ID and PC write-enable logic.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never tracked.
- ADDR_W, 5, register address width.
- CNT_W, 2, width of each per-register pending counter; max in-flight per register = 2^CNT_W - 1.

Ports:
- Clk  in  1  pipeline clock; state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset; clears all state immediately.
- issue_valid  in  1  an instruction is in ID and attempting to advance to EX this cycle.
- issue_regwrite  in  1  RegWrite control of the issuing instruction.
- issue_dest  in  ADDR_W  destination from the RegDst mux.
- rs  in  ADDR_W  source register A of the ID instruction.
- rt  in  ADDR_W  source register B of the ID instruction.
- rs_used  in  1  instruction reads rs.
- rt_used  in  1  instruction reads rt.
- wb_valid  in  1  MEM/WB is writing the register file this cycle.
- wb_dest  in  ADDR_W  register being written back.
- kill_valid  in  1  an in-flight writer was squashed (branch flush) and will never write back.
- kill_dest  in  ADDR_W  destination of the squashed writer.
- stall  out  1  hold PC and IF/ID; bubble into ID/EX.
- busy_mask  out  NUM_REGS  bit i = (count[i] != 0); bit 0 is always 0.
- err  out  1  sticky; set on counter overflow attempt or underflow.

Behaviour:
- State: count[1..NUM_REGS-1], each CNT_W bits; sticky err. Reset (async): all counts = 0, err = 0. Therefore stall = 0 and busy_mask = 0 while in reset and on the first cycle after it.
- stall is combinational from current state and inputs. It is 1 when issue_valid and any of these holds:
  - rs_used, rs != 0 and count[rs] != 0 (RAW on rs).
  - rt_used, rt != 0 and count[rt] != 0 (RAW on rt).
  - issue_regwrite, issue_dest != 0 and count[issue_dest] == max (WAW saturation).
- Accept condition: accept = issue_valid & issue_regwrite & !stall & (issue_dest != 0).
- Decrement condition: dec_wb = wb_valid & (wb_dest != 0); dec_kill = kill_valid & (kill_dest != 0).
- Per-register next-state update: count_next = count + inc − dec_wb_hit − dec_kill_hit, where each term is 0 or 1.
  - Simultaneous accept and writeback to the same register: count unchanged.
  - wb_dest == kill_dest, both valid: decrement by 2.
- Underflow: a decrement that would take a count below 0 saturates at 0 and sets err.
- Overflow: an increment past max cannot occur through accept, because stall blocks it. The check is retained anyway and sets err.
- Register 0: writes, kills and reads are ignored; never busy; never stalls.
- Latency: an accepted issue is visible in busy_mask and stall on the next cycle. A writeback clears the busy bit on the next cycle.
- Reset mid-operation: all pending counts are discarded immediately. Inputs are ignored while Reset is high.
- No internal FSM beyond the counters. err clears only on Reset.

Optional Feature:
- Macro: DEST_REG_SCOREBOARD_WB_BYPASS_EN.
- Defined: a RAW term is suppressed when wb_valid, wb_dest equals the source register and count[src] == 1. This relies on the register file's write-first, same-cycle read behaviour.
- Undefined: such a case stalls one extra cycle.
- WAW saturation logic is identical in both builds.

Test Plan:
- Reset, then idle 2 cycles -> stall = 0, busy_mask = 0, err = 0.
- Issue dest = 8 (regwrite), next cycle rs = 8, rs_used = 1, issue_valid = 1 -> stall = 1 until a cycle after wb_valid with wb_dest = 8. busy_mask[8] then returns to 0. With the bypass macro defined, stall drops in the writeback cycle itself.
- Issue dest = 5 three times without writeback (CNT_W = 2) -> count = 3. A fourth issue to 5 -> stall = 1 via WAW, count stays 3, err = 0.
- Same-cycle accepted issue dest = 12 and wb_dest = 12 with count[12] = 1 -> count stays 1, busy_mask[12] = 1.
- wb_valid with wb_dest = 20 while count[20] = 0 -> count stays 0, err = 1 and sticky. Issue and writeback to dest = 0 -> no state change, never stalls.
- Issue dest = 3 and dest = 4, then assert Reset mid-cycle (asynchronously) -> busy_mask = 0 and stall = 0 immediately, before the next edge.
